shift_reg_univ: RTL and testbench
=================================

Name: shift_reg_univ

Overview:
- N-bit universal shift register built around negative-edge D storage. It sits directly downstream of the single-bit D flip-flop stage and is the multi-bit storage/serial-conversion stage of the circuit library.
- Modes: hold, shift right, shift left, parallel load. Serial outputs are exposed at both ends.
- A consecutive-shift counter and a FULL flag tell the consumer when a complete N-bit word has been shifted in serially.

Parameters:
- N, 4, register width in bits; legal range 2..32.
- CW, $clog2(N+1), width of the shift counter. Derived; must not be overridden.

Ports:
- CK  input  1  clock; all state updates on the falling edge.
- CLR  input  1  asynchronous reset, active-high; overrides every other input.
- EN  input  1  clock enable; 0 holds all state.
- S  input  2  mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- DSR  input  1  serial data entering at the MSB during a right shift.
- DSL  input  1  serial data entering at the LSB during a left shift.
- P  input  N  parallel load data.
- Q  output  N  register contents.
- SOR  output  1  right serial out; equals Q[0] combinationally.
- SOL  output  1  left serial out; equals Q[N-1] combinationally.
- CNT  output  CW  count of consecutive same-direction shifts, saturating at N.
- FULL  output  1  high when CNT == N; combinational decode of registered CNT.

Behaviour:
- CLR=1, asynchronous, no clock edge needed: Q=0, CNT=0, DIR=0 (internal last-direction bit: 0=right, 1=left), FULL=0. State stays there while CLR is high. CLR asserted mid-shift discards the partial word.
- All other updates happen on negedge CK, only when CLR=0 and EN=1. EN=0 freezes Q, CNT and DIR.
- S=00: Q, CNT and DIR unchanged.
- S=01: Q <= {DSR, Q[N-1:1]}. If DIR==0 and CNT>0: CNT <= min(CNT+1, N). Otherwise CNT <= 1. Then DIR <= 0.
- S=10: Q <= {Q[N-2:0], DSL}. If DIR==1 and CNT>0: CNT <= min(CNT+1, N). Otherwise CNT <= 1. Then DIR <= 1.
- S=11: Q <= P, CNT <= 0. DIR unchanged.
- Saturation: further same-direction shifts at CNT==N keep CNT at N, and FULL stays 1.
- Direction reversal always restarts the count at 1, including when CNT==N. FULL drops on that edge.
- Latency:
  - Q, CNT and FULL reflect a command on the same falling edge it is sampled.
  - SOR/SOL follow Q with zero latency.
- S containing X/Z with EN=1: Q <= all X. CNT and DIR are unchanged.
- Outputs never glitch between edges, except the async CLR response and SOR/SOL following Q.

Test Plan:
- Reset: drive Q via load P=4'b1011, then pulse CLR between clock edges -> Q=0000, CNT=0, FULL=0 immediately, with no CK edge.
- Parallel load, N=4: S=11, P=1010, EN=1, one falling edge -> Q=1010, SOR=0, SOL=1, CNT=0.
- Right serial fill, N=4: after CLR, S=01 with DSR sequence 1,0,1,1 over 4 edges -> Q=1101, CNT steps 1,2,3,4, FULL=1 after edge 4. A fifth shift with DSR=0 -> Q=0110, CNT=4, FULL=1.
- Direction reversal: from that FULL state, S=10, DSL=1 -> Q=1101, CNT=1, FULL=0.
- Enable/hold: Q=0101, then S=01 with EN=0 for 3 edges, then S=00 with EN=1 for 2 edges -> Q=0101 and CNT unchanged throughout.
- Load mid-shift: after 2 right shifts (CNT=2), S=11, P=1111 -> Q=1111, CNT=0. The next right shift gives CNT=1.

Source files
------------

// File: rtl/shift_reg_univ.sv
// shift_reg_univ: N-bit universal shift register, falling-edge storage, async active-high clear
//   CK        clock, state updates on the falling edge
//   CLR       asynchronous clear, overrides everything
//   EN        clock enable
//   S         mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load
//   DSR/DSL   serial inputs at MSB (right shift) / LSB (left shift)
//   P         parallel load data
//   Q         register contents; SOR = Q[0], SOL = Q[N-1]
//   CNT/FULL  consecutive same-direction shift count (saturating at N) and CNT == N
module shift_reg_univ #(
    parameter int N  = 4,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          CK,
    input  logic          CLR,
    input  logic          EN,
    input  logic [1:0]    S,
    input  logic          DSR,
    input  logic          DSL,
    input  logic [N-1:0]  P,
    output logic [N-1:0]  Q,
    output logic          SOR,
    output logic          SOL,
    output logic [CW-1:0] CNT,
    output logic          FULL
);
    logic          dir;
    logic [CW-1:0] cnt_inc;
    assign cnt_inc = (CNT == CW'(N)) ? CNT : CNT + CW'(1);
    // a run continues only in the same direction and only after a nonzero count (load/clear restart it)
    always_ff @(negedge CK or posedge CLR)
        if (CLR) begin
            Q   <= '0;
            CNT <= '0;
            dir <= 1'b0;
        end else if (EN)
            case (S)
                2'b00: ;
                2'b01: begin
                    Q   <= {DSR, Q[N-1:1]};
                    CNT <= (!dir && CNT != '0) ? cnt_inc : CW'(1);
                    dir <= 1'b0;
                end
                2'b10: begin
                    Q   <= {Q[N-2:0], DSL};
                    CNT <= (dir && CNT != '0) ? cnt_inc : CW'(1);
                    dir <= 1'b1;
                end
                2'b11: begin
                    Q   <= P;
                    CNT <= '0;
                end
                default: Q <= 'x;
            endcase
    assign SOR  = Q[0];
    assign SOL  = Q[N-1];
    assign FULL = (CNT == CW'(N));
endmodule

// File: tb/tb_shift_reg_univ.sv
// tb_shift_reg_univ: randomized and directed self-checking bench for shift_reg_univ
module tb_shift_reg_univ;
    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);

    logic          CK = 1'b1, CLR = 1'b0, EN = 1'b0, DSR = 1'b0, DSL = 1'b0;
    logic [1:0]    S = 2'b00;
    logic [N-1:0]  P = '0;
    logic [N-1:0]  Q;
    logic          SOR, SOL, FULL;
    logic [CW-1:0] CNT;

    int checks = 0, errors = 0;
    int m_q = 0, m_cnt = 0, m_dir = 0;

    shift_reg_univ #(.N(N)) dut (
        .CK(CK), .CLR(CLR), .EN(EN), .S(S), .DSR(DSR), .DSL(DSL), .P(P),
        .Q(Q), .SOR(SOR), .SOL(SOL), .CNT(CNT), .FULL(FULL)
    );

    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference: word as an integer, count = length of current same-direction run capped at N
    task automatic model_edge();
        int run;
        if (!EN) return;
        run = (m_cnt + 1 > N) ? N : m_cnt + 1;
        case (S)
            2'b01: begin
                m_q   = (m_q >> 1) + int'(DSR) * (1 << (N - 1));
                m_cnt = (m_dir == 0 && m_cnt > 0) ? run : 1;
                m_dir = 0;
            end
            2'b10: begin
                m_q   = (m_q * 2 + int'(DSL)) % (1 << N);
                m_cnt = (m_dir == 1 && m_cnt > 0) ? run : 1;
                m_dir = 1;
            end
            2'b11: begin
                m_q   = int'(P);
                m_cnt = 0;
            end
            default: ;
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q"},    32'(Q),    32'(m_q));
        chk({tag, ".sor"},  32'(SOR),  32'(m_q % 2));
        chk({tag, ".sol"},  32'(SOL),  32'(m_q / (1 << (N - 1))));
        chk({tag, ".cnt"},  32'(CNT),  32'(m_cnt));
        chk({tag, ".full"}, 32'(FULL), 32'(m_cnt == N));
    endtask

    task automatic cyc(input string tag, input logic en, input logic [1:0] s,
                       input logic dsr, input logic dsl, input logic [N-1:0] p);
        EN = en; S = s; DSR = dsr; DSL = dsl; P = p;
        @(negedge CK);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // clear pulse placed between clock edges; response must be immediate
    task automatic clr();
        #2 CLR = 1'b1;
        #1;
        m_q = 0; m_cnt = 0; m_dir = 0;
        check_all("clr");
        CLR = 1'b0;
        #1;
    endtask

    initial begin
        clr();
        cyc("load1011", 1, 2'b11, 0, 0, 4'b1011);
        chk("load1011.q", 32'(Q), 32'hB);
        clr();
        chk("clr_async.q", 32'(Q), 32'h0);
        cyc("load1010", 1, 2'b11, 0, 0, 4'b1010);
        chk("load1010.q", 32'(Q), 32'hA);
        chk("load1010.sol", 32'(SOL), 32'h1);
        clr();
        cyc("fill1", 1, 2'b01, 1, 0, '0);
        cyc("fill2", 1, 2'b01, 0, 0, '0);
        cyc("fill3", 1, 2'b01, 1, 0, '0);
        cyc("fill4", 1, 2'b01, 1, 0, '0);
        chk("fill4.q", 32'(Q), 32'hD);
        chk("fill4.full", 32'(FULL), 32'h1);
        cyc("fill5", 1, 2'b01, 0, 0, '0);
        chk("fill5.q", 32'(Q), 32'h6);
        chk("fill5.cnt", 32'(CNT), 32'h4);
        cyc("reverse", 1, 2'b10, 0, 1, '0);
        chk("reverse.q", 32'(Q), 32'hD);
        chk("reverse.cnt", 32'(CNT), 32'h1);
        chk("reverse.full", 32'(FULL), 32'h0);
        cyc("load0101", 1, 2'b11, 0, 0, 4'b0101);
        for (int i = 0; i < 3; i++) cyc("en_off", 0, 2'b01, 1, 1, '1);
        for (int i = 0; i < 2; i++) cyc("hold", 1, 2'b00, 1, 1, '1);
        chk("hold.q", 32'(Q), 32'h5);
        clr();
        cyc("mid1", 1, 2'b01, 1, 0, '0);
        cyc("mid2", 1, 2'b01, 0, 0, '0);
        cyc("midload", 1, 2'b11, 0, 0, 4'b1111);
        chk("midload.cnt", 32'(CNT), 32'h0);
        cyc("midnext", 1, 2'b01, 0, 0, '0);
        chk("midnext.cnt", 32'(CNT), 32'h1);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) clr();
            else cyc("rand", $urandom_range(0, 9) != 0,
                     ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'($urandom_range(1, 2)),
                     1'($urandom), 1'($urandom), N'($urandom));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
